// File: rtl/sram_multiport_pkg.sv
// Shared constants for the bellmanford memory instances.
// Widths, depth, unreachable marker and an index-width helper.
package mem_pkg;

  localparam int MEM_ADDR_W = 13;
  localparam int MEM_DEPTH  = 8192;

  localparam int GRAPH_W  = 128;
  localparam int INPUT_W  = 8;
  localparam int OUTPUT_W = 16;
  localparam int WORK_W   = 128;

  localparam logic [OUTPUT_W-1:0] OUTPUT_INF = 16'hFFFF;

  // Bits needed to index a DEPTH-word array (at least 1).
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_multiport_if.sv
// Bus bundle of sram_multiport: write port plus two read ports.
// master = memory user, slave = memory.
interface sram_multiport_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 13
);
  logic              WE;
  logic [ADDR_W-1:0] WriteAddress;
  logic [DATA_W-1:0] WriteBus;
  logic [ADDR_W-1:0] ReadAddress1;
  logic [DATA_W-1:0] ReadBus1;
  logic [ADDR_W-1:0] ReadAddress2;
  logic [DATA_W-1:0] ReadBus2;

  modport master (
    output WE, WriteAddress, WriteBus,
    output ReadAddress1, ReadAddress2,
    input  ReadBus1, ReadBus2
  );

  modport slave (
    input  WE, WriteAddress, WriteBus,
    input  ReadAddress1, ReadAddress2,
    output ReadBus1, ReadBus2
  );
endinterface

// File: rtl/sram_multiport_read_port.sv
// Range-checked combinational read mux for one port.
// addr_i, mem_i -> data_o (zero when addr_i >= DEPTH).
module sram_read_port
  import mem_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] mem_i [DEPTH],
  output logic [DATA_W-1:0] data_o
);

  localparam int IW = idx_w(DEPTH);

  logic [IW-1:0] idx;
  assign idx = addr_i[IW-1:0];

  always_comb begin
    data_o = '0;
    if (32'(addr_i) < DEPTH)
      data_o = mem_i[idx];
  end

endmodule

// File: rtl/sram_multiport.sv
// Single-clock SRAM: 1-2 async read ports, optional sync write.
// clock/reset plain; bus = sram_multiport_if.slave.
module sram_multiport
  import mem_pkg::*;
#(
  parameter int DATA_W    = GRAPH_W,
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DEPTH     = MEM_DEPTH,
  parameter int NUM_READ  = 2,
  parameter int HAS_WRITE = 1
) (
  input logic       clock,
  input logic       reset,
  sram_multiport_if.slave bus
);

  localparam int IW = idx_w(DEPTH);

  if (NUM_READ < 1 || NUM_READ > 2) begin : g_bad_nr
    $fatal(1, "sram_multiport: NUM_READ must be 1 or 2");
  end
  if (64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
    $fatal(1, "sram_multiport: DEPTH exceeds 2**ADDR_W");
  end

  // Never cleared: backdoor-loaded contents survive reset.
  logic [DATA_W-1:0] Register [DEPTH];

  if (HAS_WRITE != 0) begin : g_wr
    logic [IW-1:0] widx;
    logic          wr_en;
    assign widx  = bus.WriteAddress[IW-1:0];
    // Out-of-range writes are dropped, not aliased.
    assign wr_en = !reset && bus.WE &&
                   (32'(bus.WriteAddress) < DEPTH);

    always_ff @(posedge clock) begin
      if (wr_en)
        Register[widx] <= bus.WriteBus;
    end
  end

  sram_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) u_rd1 (
    .addr_i(bus.ReadAddress1),
    .mem_i (Register),
    .data_o(bus.ReadBus1)
  );

  if (NUM_READ == 2) begin : g_rd2
    sram_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
    ) u_rd2 (
      .addr_i(bus.ReadAddress2),
      .mem_i (Register),
      .data_o(bus.ReadBus2)
    );
  end else begin : g_no_rd2
    assign bus.ReadBus2 = '0;
  end

endmodule

// File: tb/tb_sram_multiport.sv
// Bench for sram_multiport: four flavours against a word-array model.
// Directed vectors plus a negedge compare of every read bus.
module tb_sram_multiport;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_multiport_if #(.DATA_W(GRAPH_W),  .ADDR_W(13)) ifA ();
  sram_multiport_if #(.DATA_W(OUTPUT_W), .ADDR_W(13)) ifB ();
  sram_multiport_if #(.DATA_W(INPUT_W),  .ADDR_W(13)) ifC ();
  sram_multiport_if #(.DATA_W(INPUT_W),  .ADDR_W(13)) ifD ();

  sram_multiport #(
    .DATA_W(GRAPH_W), .NUM_READ(2), .HAS_WRITE(1)
  ) uA (.clock(clk), .reset(rst), .bus(ifA));

  sram_multiport #(
    .DATA_W(OUTPUT_W), .NUM_READ(1), .HAS_WRITE(1)
  ) uB (.clock(clk), .reset(rst), .bus(ifB));

  sram_multiport #(
    .DATA_W(INPUT_W), .NUM_READ(1), .HAS_WRITE(0)
  ) uC (.clock(clk), .reset(rst), .bus(ifC));

  sram_multiport #(
    .DATA_W(INPUT_W), .DEPTH(100), .NUM_READ(1), .HAS_WRITE(1)
  ) uD (.clock(clk), .reset(rst), .bus(ifD));

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a word array per instance plus a written-flag.
  logic [127:0] mA [8192];
  bit           kA [8192];
  logic [15:0]  mB [8192];
  bit           kB [8192];
  logic [7:0]   mC [8192];
  bit           kC [8192];
  logic [7:0]   mD [100];
  bit           kD [100];

  always @(posedge clk) begin
    if (!rst) begin
      if (ifA.WE === 1'b1) begin
        mA[ifA.WriteAddress] <= ifA.WriteBus;
        kA[ifA.WriteAddress] <= 1'b1;
      end
      if (ifB.WE === 1'b1) begin
        mB[ifB.WriteAddress] <= ifB.WriteBus;
        kB[ifB.WriteAddress] <= 1'b1;
      end
      if (ifD.WE === 1'b1 && ifD.WriteAddress < 100) begin
        mD[ifD.WriteAddress] <= ifD.WriteBus;
        kD[ifD.WriteAddress] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (kA[ifA.ReadAddress1])
      chk("A.rd1", ifA.ReadBus1, mA[ifA.ReadAddress1]);
    if (kA[ifA.ReadAddress2])
      chk("A.rd2", ifA.ReadBus2, mA[ifA.ReadAddress2]);
    if (kB[ifB.ReadAddress1])
      chk("B.rd1", ifB.ReadBus1, 128'(mB[ifB.ReadAddress1]));
    chk("B.rd2", ifB.ReadBus2, 128'h0);
    if (kC[ifC.ReadAddress1])
      chk("C.rd1", ifC.ReadBus1, 128'(mC[ifC.ReadAddress1]));
    chk("C.rd2", ifC.ReadBus2, 128'h0);
    if (ifD.ReadAddress1 >= 100)
      chk("D.oor", ifD.ReadBus1, 128'h0);
    else if (kD[ifD.ReadAddress1])
      chk("D.rd1", ifD.ReadBus1, 128'(mD[ifD.ReadAddress1]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifA.WE = 0; ifA.WriteAddress = 0; ifA.WriteBus = 0;
    ifA.ReadAddress1 = 0; ifA.ReadAddress2 = 0;
    ifB.WE = 0; ifB.WriteAddress = 0; ifB.WriteBus = 0;
    ifB.ReadAddress1 = 0; ifB.ReadAddress2 = 0;
    ifC.WE = 0; ifC.WriteAddress = 0; ifC.WriteBus = 0;
    ifC.ReadAddress1 = 0; ifC.ReadAddress2 = 0;
    ifD.WE = 0; ifD.WriteAddress = 0; ifD.WriteBus = 0;
    ifD.ReadAddress1 = 0; ifD.ReadAddress2 = 0;

    uC.Register[0] = 8'h11;
    mC[0] = 8'h11;
    kC[0] = 1'b1;

    repeat (2) step();
    chk("rst.B.rd2", ifB.ReadBus2, 128'h0);
    chk("rst.C.rd2", ifC.ReadBus2, 128'h0);
    chk("rst.C.pre", ifC.ReadBus1, 128'h11);
    rst = 1'b0;

    // Two-port load and address swap
    ifA.WE = 1; ifA.WriteAddress = 0; ifA.WriteBus = 128'h1;
    step();
    ifA.WriteAddress = 8191; ifA.WriteBus = 128'hDEAD;
    step();
    ifA.WE = 0;
    ifA.ReadAddress1 = 0; ifA.ReadAddress2 = 8191;
    #1;
    chk("t1.rd1", ifA.ReadBus1, 128'h1);
    chk("t1.rd2", ifA.ReadBus2, 128'hDEAD);
    ifA.ReadAddress1 = 8191; ifA.ReadAddress2 = 0;
    #1;
    chk("t1.swap1", ifA.ReadBus1, 128'hDEAD);
    chk("t1.swap2", ifA.ReadBus2, 128'h1);

    // Write timing on the 16-bit port
    step();
    ifB.WE = 1; ifB.WriteAddress = 5; ifB.WriteBus = 16'h1111;
    ifB.ReadAddress1 = 5;
    step();
    ifB.WriteBus = 16'h00FF;
    #1;
    chk("t2.pre", ifB.ReadBus1, 128'h1111);
    step();
    chk("t2.ff", ifB.ReadBus1, 128'h00FF);
    ifB.WriteBus = 16'hFFFF;
    step();
    chk("t2.ffff", ifB.ReadBus1, 128'hFFFF);

    // Reset blocks writes, reads continue
    ifB.WriteAddress = 3; ifB.WriteBus = 16'hABCD;
    step();
    ifB.WriteAddress = 7; ifB.WriteBus = 16'h0007;
    step();
    rst = 1'b1;
    ifB.WriteAddress = 7; ifB.WriteBus = 16'h1234;
    ifB.ReadAddress1 = 3;
    #1;
    chk("t3.rst3", ifB.ReadBus1, 128'hABCD);
    repeat (3) step();
    chk("t3.rst3b", ifB.ReadBus1, 128'hABCD);
    ifB.ReadAddress1 = 7;
    #1;
    chk("t3.rst7", ifB.ReadBus1, 128'h0007);
    rst = 1'b0; ifB.WE = 0;
    step();
    chk("t3.post7", ifB.ReadBus1, 128'h0007);
    ifB.ReadAddress1 = 3;
    #1;
    chk("t3.post3", ifB.ReadBus1, 128'hABCD);

    // Read-only flavour ignores writes
    ifC.WE = 1; ifC.WriteAddress = 0; ifC.WriteBus = 8'h55;
    repeat (4) begin
      step();
      ifC.WE = ~ifC.WE;
    end
    ifC.WE = 0;
    chk("t4.rd1", ifC.ReadBus1, 128'h11);
    chk("t4.rd2", ifC.ReadBus2, 128'h0);

    // Out-of-range on a 100-word array
    ifD.ReadAddress1 = 200;
    #1;
    chk("t5.oor", ifD.ReadBus1, 128'h0);
    ifD.WE = 1; ifD.WriteAddress = 72; ifD.WriteBus = 8'h33;
    step();
    ifD.WriteAddress = 99; ifD.WriteBus = 8'h01;
    step();
    ifD.WriteAddress = 200; ifD.WriteBus = 8'hAA;
    step();
    ifD.WE = 0;
    ifD.ReadAddress1 = 72;
    #1;
    chk("t5.alias72", ifD.ReadBus1, 128'h33);
    ifD.ReadAddress1 = 99;
    #1;
    chk("t5.w99a", ifD.ReadBus1, 128'h01);
    ifD.WE = 1; ifD.WriteAddress = 99; ifD.WriteBus = 8'h77;
    step();
    ifD.WE = 0;
    chk("t5.w99", ifD.ReadBus1, 128'h77);
    ifD.ReadAddress1 = 200;
    #1;
    chk("t5.oor2", ifD.ReadBus1, 128'h0);

    // Same-address collision on both ports
    ifA.WE = 1; ifA.WriteAddress = 10; ifA.WriteBus = 128'h0;
    step();
    ifA.ReadAddress1 = 10; ifA.ReadAddress2 = 10;
    ifA.WriteBus = 128'hF0;
    #1;
    chk("t6.pre1", ifA.ReadBus1, 128'h0);
    chk("t6.pre2", ifA.ReadBus2, 128'h0);
    step();
    ifA.WE = 0;
    chk("t6.post1", ifA.ReadBus1, 128'hF0);
    chk("t6.post2", ifA.ReadBus2, 128'hF0);

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
